// File: rtl/bounce_rect_ctl.sv
// Rectangle position controller: tracks the mouse, and on a left click drops the
// rectangle under gravity with damped floor bounces. Optional macro CLICK_REARM_EN.
module bounce_rect_ctl #(
  parameter int COORD_W     = 12,
  parameter int SCREEN_H    = 600,
  parameter int RECT_H      = 64,
  parameter int TICK_DIV    = 833333,
  parameter int GRAVITY     = 1,
  parameter int VEL_W       = 8,
  parameter int MAX_BOUNCES = 5,
  parameter int DAMP_SHIFT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mouse_left,
  input  logic [COORD_W-1:0] mouse_xpos,
  input  logic [COORD_W-1:0] mouse_ypos,
  output logic [COORD_W-1:0] xpos,
  output logic [COORD_W-1:0] ypos,
  output logic               busy,
  output logic [3:0]         bounce_cnt
);

  localparam logic [COORD_W-1:0] FLOOR = COORD_W'(SCREEN_H - RECT_H);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [VEL_W-1:0] GRAV = VEL_W'(GRAVITY);

  typedef enum logic [1:0] {TRACK, FALL, RISE, REST} state_t;

  state_t             state;
  logic               mouse_left_q;
  logic [CNT_W-1:0]   tick_cnt;
  logic [VEL_W-1:0]   vel;

  logic               click, tick;
  logic [COORD_W-1:0] y_clamp, y_up;
  logic [VEL_W:0]     vel_sum;
  logic [VEL_W-1:0]   vel_n, v_b, vel_dn;
  logic [COORD_W:0]   y_n;
  logic [3:0]         bounce_inc;

  assign click   = mouse_left & ~mouse_left_q;
  assign tick    = (tick_cnt == CNT_W'(TICK_DIV - 1));
  assign y_clamp = (mouse_ypos > FLOOR) ? FLOOR : mouse_ypos;

  // Falling step: saturating velocity, position sum one bit wider to catch overflow
  assign vel_sum    = {1'b0, vel} + {1'b0, GRAV};
  assign vel_n      = vel_sum[VEL_W] ? '1 : vel_sum[VEL_W-1:0];
  assign y_n        = {1'b0, ypos} + (COORD_W+1)'(vel_n);
  assign v_b        = vel_n >> DAMP_SHIFT;
  assign bounce_inc = bounce_cnt + 4'd1;

  // Rising step: both position and velocity clamp at zero
  assign y_up   = (ypos >= COORD_W'(vel)) ? ypos - COORD_W'(vel) : '0;
  assign vel_dn = (vel > GRAV) ? vel - GRAV : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= TRACK;
      mouse_left_q <= 1'b0;
      tick_cnt     <= '0;
      vel          <= '0;
      xpos         <= '0;
      ypos         <= '0;
      busy         <= 1'b0;
      bounce_cnt   <= '0;
    end else begin
      mouse_left_q <= mouse_left;
      tick_cnt     <= tick ? '0 : tick_cnt + CNT_W'(1);
      case (state)
        TRACK: begin
          xpos <= mouse_xpos;
          ypos <= y_clamp;
          if (click) begin
            vel        <= '0;
            bounce_cnt <= '0;
            tick_cnt   <= '0;
            state      <= FALL;
            busy       <= 1'b1;
          end
        end
        FALL: if (tick) begin
          if (y_n < {1'b0, FLOOR}) begin
            ypos <= y_n[COORD_W-1:0];
            vel  <= vel_n;
          end else begin
            ypos       <= FLOOR;
            bounce_cnt <= bounce_inc;
            // Hitting the bounce limit takes priority over a further rise
            if (bounce_inc == 4'(MAX_BOUNCES) || v_b == '0) begin
              vel   <= '0;
              state <= REST;
              busy  <= 1'b0;
            end else begin
              vel   <= v_b;
              state <= RISE;
            end
          end
        end
        RISE: if (tick) begin
          ypos <= y_up;
          vel  <= vel_dn;
          if (vel_dn == '0) state <= FALL;
        end
        REST: begin
`ifdef CLICK_REARM_EN
          if (click) begin
            bounce_cnt <= '0;
            state      <= TRACK;
          end
`endif
        end
        default: state <= TRACK;
      endcase
    end
  end

endmodule

// File: tb/tb_bounce_rect_ctl.sv
// Randomized self-checking bench for bounce_rect_ctl against a per-tick trajectory model.
module tb_bounce_rect_ctl;
  localparam int TD = 4;
  localparam int FLOOR = 536;

  logic        clk = 1'b0;
  logic        rst, mouse_left;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic [11:0] xpos, ypos;
  logic        busy;
  logic [3:0]  bounce_cnt;

  int total = 0;
  int bad = 0;

  // Per-tick expectation: index i is the state after i motion steps
  int ty[$];
  int tbc[$];
  bit tbusy[$];

  bounce_rect_ctl #(
    .COORD_W(12), .SCREEN_H(600), .RECT_H(64), .TICK_DIV(TD), .GRAVITY(1),
    .VEL_W(8), .MAX_BOUNCES(5), .DAMP_SHIFT(1)
  ) dut (
    .clk(clk), .rst(rst), .mouse_left(mouse_left), .mouse_xpos(mouse_xpos),
    .mouse_ypos(mouse_ypos), .xpos(xpos), .ypos(ypos), .busy(busy), .bounce_cnt(bounce_cnt)
  );

  always #5 clk = ~clk;

  function automatic int clamp_y(input int y);
    return (y > FLOOR) ? FLOOR : y;
  endfunction

  // Physics from the drop rules, stepped until the rectangle settles
  task automatic build_traj(input int start);
    int y, v, b, vn, vb;
    bit rising, resting;
    y = start; v = 0; b = 0; rising = 0; resting = 0;
    ty.delete(); tbc.delete(); tbusy.delete();
    ty.push_back(y); tbc.push_back(b); tbusy.push_back(1'b1);
    for (int i = 0; i < 2000 && !resting; i++) begin
      if (!rising) begin
        vn = (v + 1 > 255) ? 255 : v + 1;
        if (y + vn < FLOOR) begin
          y = y + vn; v = vn;
        end else begin
          y = FLOOR; b = b + 1; vb = vn / 2;
          if (b == 5 || vb == 0) begin resting = 1; v = 0; end
          else begin rising = 1; v = vb; end
        end
      end else begin
        y = (y >= v) ? y - v : 0;
        v = (v > 1) ? v - 1 : 0;
        if (v == 0) rising = 0;
      end
      ty.push_back(y); tbc.push_back(b); tbusy.push_back(!resting);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mouse_left = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mouse_left = 1'b1;
    mouse_xpos = 12'd321; mouse_ypos = 12'd123;
    @(negedge clk); @(negedge clk);
    total++;
    if (xpos !== 12'd0 || ypos !== 12'd0 || busy !== 1'b0 || bounce_cnt !== 4'd0) begin
      bad++;
      $display("FAIL reset: x=%0d y=%0d busy=%0b bc=%0d, want all zero", xpos, ypos, busy, bounce_cnt);
    end
    rst = 1'b0; mouse_left = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_track();
    int xs[4] = '{100, 7, 4095, 999};
    int ys[4] = '{200, 590, 536, 535};
    int x, y;
    for (int i = 0; i < 24; i++) begin
      if (i < 4) begin x = xs[i]; y = ys[i]; end
      else begin x = $urandom_range(0, 4095); y = $urandom_range(0, 1200); end
      mouse_xpos = 12'(x); mouse_ypos = 12'(y);
      @(negedge clk);
      total++;
      if (xpos !== 12'(x) || ypos !== 12'(clamp_y(y))) begin
        bad++;
        $display("FAIL track: got (%0d,%0d) want (%0d,%0d)", xpos, ypos, x, clamp_y(y));
      end
    end
  endtask

  // Click at the next edge, then compare every cycle against the model.
  // noisy: random clicks while airborne; otherwise the button stays held.
  task automatic run_drop(input int x0, input int y0, input bit noisy, input int min_cycles);
    int k, last, ncyc;
    mouse_left = 1'b0; mouse_xpos = 12'(x0); mouse_ypos = 12'(y0);
    @(negedge clk);
    build_traj(clamp_y(y0));
    last = ty.size() - 1;
    ncyc = (last + 3) * TD;
    if (ncyc < min_cycles) ncyc = min_cycles;
    mouse_left = 1'b1;
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      k = j / TD;
      if (k > last) k = last;
      total++;
      if (ypos !== 12'(ty[k]) || bounce_cnt !== 4'(tbc[k]) || busy !== tbusy[k] || xpos !== 12'(x0)) begin
        bad++;
        $display("FAIL drop cyc%0d: y=%0d bc=%0d busy=%0b x=%0d want y=%0d bc=%0d busy=%0b x=%0d",
                 j, ypos, bounce_cnt, busy, xpos, ty[k], tbc[k], tbusy[k], x0);
      end
      mouse_xpos = 12'($urandom_range(0, 4095));
      mouse_ypos = 12'($urandom_range(0, 700));
      if (noisy) mouse_left = tbusy[k] ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic test_drop500();
    int exp_y[12] = '{501, 503, 506, 510, 515, 521, 528, 536, 532, 529, 527, 526};
    do_reset();
    mouse_xpos = 12'd40; mouse_ypos = 12'd500; mouse_left = 1'b0;
    @(negedge clk);
    mouse_left = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      repeat (TD) @(negedge clk);
      total++;
      if (ypos !== 12'(exp_y[i]) || busy !== 1'b1 || bounce_cnt !== ((i >= 7) ? 4'd1 : 4'd0)) begin
        bad++;
        $display("FAIL drop500 tick%0d: y=%0d busy=%0b bc=%0d want y=%0d", i + 1, ypos, busy, bounce_cnt, exp_y[i]);
      end
    end
    mouse_left = 1'b0;
  endtask

  task automatic test_full_from_top();
    do_reset();
    run_drop(250, 0, 1'b0, 0);
    total++;
    if (ypos !== 12'd536 || busy !== 1'b0 || bounce_cnt > 4'd5 || bounce_cnt == 4'd0) begin
      bad++;
      $display("FAIL full_rest: y=%0d busy=%0b bc=%0d want y=536 busy=0 bc in 1..5", ypos, busy, bounce_cnt);
    end
  endtask

  task automatic test_random_drops();
    for (int n = 0; n < 6; n++) begin
      do_reset();
      run_drop($urandom_range(0, 4095), $urandom_range(0, 700), 1'b1, 0);
    end
  endtask

  task automatic test_held_button();
    do_reset();
    run_drop(77, 300, 1'b0, 1000);
  endtask

  task automatic test_reset_mid_rise();
    do_reset();
    mouse_xpos = 12'd60; mouse_ypos = 12'd500; mouse_left = 1'b0;
    @(negedge clk);
    mouse_left = 1'b1;
    repeat (9 * TD + 1) @(negedge clk);
    total++;
    if (ypos !== 12'd532 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_rise: y=%0d busy=%0b want y=532 busy=1", ypos, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mouse_left = 1'b0;
    total++;
    if (xpos !== 12'd0 || ypos !== 12'd0 || busy !== 1'b0 || bounce_cnt !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid_rise: x=%0d y=%0d busy=%0b bc=%0d want zeros", xpos, ypos, busy, bounce_cnt);
    end
    mouse_xpos = 12'd123; mouse_ypos = 12'd456;
    @(negedge clk);
    total++;
    if (xpos !== 12'd123 || ypos !== 12'd456) begin
      bad++;
      $display("FAIL track_after_reset: got (%0d,%0d) want (123,456)", xpos, ypos);
    end
  endtask

  task automatic test_rest_click();
    do_reset();
    run_drop(500, 400, 1'b0, 0);
    mouse_left = 1'b0;
    @(negedge clk);
    mouse_left = 1'b1; mouse_xpos = 12'd11; mouse_ypos = 12'd22;
    @(negedge clk);
`ifdef CLICK_REARM_EN
    total++;
    if (bounce_cnt !== 4'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rearm_clear: bc=%0d busy=%0b want 0 0", bounce_cnt, busy);
    end
    @(negedge clk);
    total++;
    if (xpos !== 12'd11 || ypos !== 12'd22) begin
      bad++;
      $display("FAIL rearm_track: got (%0d,%0d) want (11,22)", xpos, ypos);
    end
`else
    repeat (5) @(negedge clk);
    total++;
    if (xpos !== 12'd500 || ypos !== 12'd536 || busy !== 1'b0 || bounce_cnt !== 4'(tbc[tbc.size()-1])) begin
      bad++;
      $display("FAIL rest_hold: x=%0d y=%0d busy=%0b bc=%0d want x=500 y=536 busy=0 bc=%0d",
               xpos, ypos, busy, bounce_cnt, tbc[tbc.size()-1]);
    end
`endif
    mouse_left = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mouse_left = 1'b0; mouse_xpos = '0; mouse_ypos = '0;
    test_reset();
    test_track();
    test_drop500();
    test_full_from_top();
    test_random_drops();
    test_held_button();
    test_reset_mid_rise();
    test_rest_click();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bounce_rect_ctl.md
# bounce_rect_ctl

Position controller for the mouse-driven rectangle in the VGA pipeline. It sits between the mouse interface and the rectangle drawer. While idle it tracks the mouse. A left click drops the rectangle under a constant-gravity model, with a parametrised number of damped bounces on the screen floor, until it comes to rest. Motion steps come from an internal frame-rate tick; there is no derived clock.

## Interface
Parameters:
- COORD_W, 12: width of all coordinates.
- SCREEN_H, 600: visible screen height in pixels.
- RECT_H, 64: rectangle height. FLOOR = SCREEN_H - RECT_H.
- TICK_DIV, 833333: clk cycles per motion step. Must be ≥ 2.
- GRAVITY, 1: velocity increment per step.
- VEL_W, 8: velocity register width.
- MAX_BOUNCES, 5: floor contacts before forced rest. Range 1..15.
- DAMP_SHIFT, 1: velocity right-shift applied at each floor contact.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- mouse_left  in  1  left button level, synchronous to clk.
- mouse_xpos  in  COORD_W  mouse x.
- mouse_ypos  in  COORD_W  mouse y.
- xpos  out  COORD_W  rectangle x.
- ypos  out  COORD_W  rectangle y.
- busy  out  1  high in FALL or RISE.
- bounce_cnt  out  4  floor contacts since the last drop.

## Operation
- States: TRACK, FALL, RISE, REST.
- Click detection: click = mouse_left & ~mouse_left_q. A held button generates no further clicks.
- TRACK:
  - xpos <= mouse_xpos and ypos <= min(mouse_ypos, FLOOR), every cycle.
  - On click: latch the same clamped values, vel <= 0, bounce_cnt <= 0, restart the tick counter, go to FALL.
- FALL, on each tick:
  - vel_n = sat(vel + GRAVITY), saturating at 2^VEL_W-1.
  - y_n = ypos + vel_n, computed COORD_W+1 bits wide.
  - If y_n < FLOOR: ypos <= y_n, vel <= vel_n.
  - Otherwise (floor contact): ypos <= FLOOR and bounce_cnt++. Let v_b = vel_n >> DAMP_SHIFT. If the incremented count equals MAX_BOUNCES, or v_b == 0, go to REST with vel <= 0. Else go to RISE with vel <= v_b.
- RISE, on each tick:
  - ypos <= (ypos ≥ vel) ? ypos - vel : 0.
  - vel <= (vel > GRAVITY) ? vel - GRAVITY : 0.
  - If the new vel is 0, go to FALL.
- REST: hold xpos, ypos and bounce_cnt. A click is handled as described under Configuration.
- xpos is frozen in FALL, RISE and REST.
- Clicks in FALL and RISE are ignored.

## Timing
- Reset values: xpos = 0, ypos = 0, busy = 0, bounce_cnt = 0, state = TRACK, vel = 0, tick counter = 0, mouse_left_q = 0.
- TRACK latency: 1 cycle from mouse inputs to xpos/ypos.
- Tick counter: counts 0..TICK_DIV-1 and wraps. tick is high for the cycle in which the count equals TICK_DIV-1.
- After a click at cycle c, the first FALL step is applied at cycle c+TICK_DIV.
- A state transition and its position update take effect on the same tick edge.
- busy is registered and changes on the same edge as the state.
- rst has priority over everything; reset mid-fall returns to TRACK on the next edge.
- Simultaneous floor contact and bounce limit: REST wins over RISE.

## Configuration
- CLICK_REARM_EN
  - Defined: a click in REST returns to TRACK, with xpos/ypos following the mouse from the next cycle and bounce_cnt cleared.
  - Undefined: REST is left only by rst, and clicks in REST are ignored.

## Test plan
All scenarios use TICK_DIV=4, GRAVITY=1, SCREEN_H=600, RECT_H=64 (FLOOR=536), DAMP_SHIFT=1, MAX_BOUNCES=5.

- Tracking: mouse set to (100,200) -> xpos=100, ypos=200 one cycle later. mouse_ypos=590 -> ypos=536.
- Drop from y=500: ypos sequence per tick is 501, 503, 506, 510, 515, 521, 528, 536. bounce_cnt=1 at the 8th tick. Then RISE gives 532, 529, 527, 526, then FALL. busy=1 throughout.
- Full sequence: drop from y=0 -> exactly MAX_BOUNCES contacts or fewer (damping reaches v_b=0), ending in REST with ypos=536, busy=0, bounce_cnt ≤ 5.
- Held button and mid-fall clicks: mouse_left held high for 1000 cycles in TRACK -> a single drop. Additional clicks during FALL/RISE -> trajectory unchanged.
- Reset mid-RISE: rst pulsed for one cycle -> next cycle xpos=0, ypos=0, busy=0, bounce_cnt=0. The cycle after that, TRACK follows the mouse.
- REST click: with CLICK_REARM_EN defined -> TRACK, following the mouse next cycle. Undefined -> ypos stays at 536.
